// File: rtl/parking_slot_ctrl.sv
// -----------------------------------------------------------------------------
// parking_slot_ctrl
//
// Front end of the six-bay check-in/check-out stage. Synchronizes and
// debounces the operator push-button, validates the bay selector, keeps the
// occupancy bitmap and runs the free-running minute timebase. Each accepted
// press is decoded into a check-in (bay was empty) or a check-out (bay was
// occupied) and committed downstream with a single-cycle strobe.
//
// Parameters
//   MIN_DIV   clock cycles per minute tick (>= 2)
//   DEBOUNCE  consecutive stable cycles needed to accept a level change (1..255)
//
// Ports
//   clk        in   system clock, rising-edge
//   rst_n      in   synchronous, active-low reset
//   press_raw  in   asynchronous push-button level, active high
//   selector   in   [3:0] bay number, 1..6 valid
//   timer      out  [10:0] live minute counter (wraps 2047 -> 0)
//   stamp      out  [10:0] minute value captured at the last valid accept
//   sel_out    out  [3:0] bay of the last valid accept
//   free       out  1 = last valid press was a check-in, 0 = check-out
//   press_out  out  one-cycle commit strobe, two cycles after the accept
//   err_sel    out  one-cycle pulse for an accepted press with a bad selector
//   occupied   out  [5:0] occupancy bitmap, bit i-1 is bay i
//   occ_count  out  [2:0] number of occupied bays
//   full       out  all six bays occupied
//
// Handshake: downstream samples free/sel_out/stamp on the rising edge of
// press_out. Those fields are written one cycle before press_out goes high
// and are not touched again until the next valid accept, which is always at
// least 2*DEBOUNCE+1 cycles later, so no ready/backpressure is needed.
// -----------------------------------------------------------------------------
module parking_slot_ctrl #(
    parameter int MIN_DIV  = 6000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        press_raw,
    input  logic [3:0]  selector,
    output logic [10:0] timer,
    output logic [10:0] stamp,
    output logic [3:0]  sel_out,
    output logic        free,
    output logic        press_out,
    output logic        err_sel,
    output logic [5:0]  occupied,
    output logic [2:0]  occ_count,
    output logic        full
);

    localparam int             PW       = $clog2(MIN_DIV);
    localparam logic [PW-1:0]  PRE_LAST = PW'(MIN_DIV - 1);
    localparam logic [7:0]     DB_LIMIT = 8'(DEBOUNCE);

    typedef enum logic {
        RELEASED = 1'b0,
        HELD     = 1'b1
    } db_state_t;

    db_state_t     db_state;
    logic [7:0]    db_cnt;
    logic          armed;
    logic          sync_1;
    logic          sync_2;
    logic [PW-1:0] prescale;
    logic          cmd_commit;   // valid command written this cycle; strobe next

    logic          accept;
    logic          sel_valid;
    logic [5:0]    bay_mask;
    logic [5:0]    occ_next;

    function automatic logic [2:0] popcount6(input logic [5:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 6; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Accept cycle: the debounced press completes while armed. Unarmed
    // completions (the first press after reset, or a button held through
    // reset) only arm the controller.
    assign accept = (db_state == RELEASED) && (db_cnt == DB_LIMIT) && armed;

    always_comb begin
        sel_valid = 1'b0;
        bay_mask  = 6'd0;
        if (selector >= 4'd1 && selector <= 4'd6) begin
            sel_valid = 1'b1;
            bay_mask  = 6'd1 << (selector - 4'd1);
        end
    end

    // A valid accept always toggles the selected bay: empty -> occupied on
    // check-in, occupied -> empty on check-out.
    assign occ_next = occupied ^ bay_mask;
    assign full     = (occ_count == 3'd6);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_state   <= RELEASED;
            db_cnt     <= 8'd0;
            armed      <= 1'b0;
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            prescale   <= '0;
            timer      <= 11'd0;
            stamp      <= 11'd0;
            sel_out    <= 4'd0;
            free       <= 1'b0;
            press_out  <= 1'b0;
            err_sel    <= 1'b0;
            cmd_commit <= 1'b0;
            occupied   <= 6'd0;
            occ_count  <= 3'd0;
        end else begin
            sync_1 <= press_raw;
            sync_2 <= sync_1;

            if (prescale == PRE_LAST) begin
                prescale <= '0;
                timer    <= timer + 11'd1;
            end else begin
                prescale <= prescale + PW'(1);
            end

            // The limit test comes before the level test so that a level
            // stable for exactly DEBOUNCE cycles is accepted.
            case (db_state)
                RELEASED: begin
                    if (db_cnt == DB_LIMIT) begin
                        db_state <= HELD;
                        db_cnt   <= 8'd0;
                        armed    <= 1'b1;
                    end else if (sync_2) begin
                        db_cnt <= db_cnt + 8'd1;
                    end else begin
                        db_cnt <= 8'd0;
                    end
                end
                HELD: begin
                    if (db_cnt == DB_LIMIT) begin
                        db_state <= RELEASED;
                        db_cnt   <= 8'd0;
                    end else if (!sync_2) begin
                        db_cnt <= db_cnt + 8'd1;
                    end else begin
                        db_cnt <= 8'd0;
                    end
                end
                default: begin
                    db_state <= RELEASED;
                    db_cnt   <= 8'd0;
                end
            endcase

            err_sel    <= accept && !sel_valid;
            cmd_commit <= accept && sel_valid;
            press_out  <= cmd_commit;

            if (accept && sel_valid) begin
                occupied  <= occ_next;
                occ_count <= popcount6(occ_next);
                free      <= ~|(occupied & bay_mask);
                sel_out   <= selector;
                stamp     <= timer;   // pre-increment value if a tick lands here
            end
        end
    end

endmodule

// File: tb/tb_parking_slot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_slot_ctrl
//
// Directed and randomized presses against a behavioural model of the parking
// front end. The model tracks bays as an array, the minute counter as
// (active edges since reset) / MIN_DIV, and predicts strobe timing as fixed
// offsets from the raw button rise.
// -----------------------------------------------------------------------------
module tb_parking_slot_ctrl;

    localparam int MIN_DIV  = 4;
    localparam int DEBOUNCE = 4;
    localparam int A_OFS    = 2 + DEBOUNCE;   // raw rise -> accept cycle

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        press_raw = 1'b0;
    logic [3:0]  selector = 4'd0;
    logic [10:0] timer;
    logic [10:0] stamp;
    logic [3:0]  sel_out;
    logic        free;
    logic        press_out;
    logic        err_sel;
    logic [5:0]  occupied;
    logic [2:0]  occ_count;
    logic        full;

    parking_slot_ctrl #(
        .MIN_DIV  (MIN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .press_raw (press_raw),
        .selector  (selector),
        .timer     (timer),
        .stamp     (stamp),
        .sel_out   (sel_out),
        .free      (free),
        .press_out (press_out),
        .err_sel   (err_sel),
        .occupied  (occupied),
        .occ_count (occ_count),
        .full      (full)
    );

    always #5 clk = ~clk;

    // Active edges since the last reset edge; timer model is n_edges/MIN_DIV.
    int n_edges = 0;
    always @(posedge clk) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          occ_m [1:6];
    logic        free_m;
    logic [3:0]  sel_m;
    logic [10:0] stamp_m;
    bit          armed_m;

    function automatic logic [5:0] occ_vec();
        logic [5:0] v;
        for (int i = 1; i <= 6; i++) v[i-1] = occ_m[i];
        return v;
    endfunction

    function automatic int occ_num();
        int c;
        c = 0;
        for (int i = 1; i <= 6; i++) c += int'(occ_m[i]);
        return c;
    endfunction

    function automatic int timer_m();
        return (n_edges / MIN_DIV) % 2048;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string when);
        check({when, "_occupied"},  32'(occupied),  32'(occ_vec()));
        check({when, "_occ_count"}, 32'(occ_count), 32'(occ_num()));
        check({when, "_full"},      32'(full),      32'(occ_num() == 6));
        check({when, "_free"},      32'(free),      32'(free_m));
        check({when, "_sel_out"},   32'(sel_out),   32'(sel_m));
        check({when, "_stamp"},     32'(stamp),     32'(stamp_m));
        check({when, "_timer"},     32'(timer),     32'(timer_m()));
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 6; i++) occ_m[i] = 1'b0;
        free_m  = 1'b0;
        sel_m   = 4'd0;
        stamp_m = 11'd0;
        armed_m = 1'b0;
    endtask

    // Holds reset for three edges and checks every output is cleared.
    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_timer",     32'(timer),     32'd0);
        check("rst_stamp",     32'(stamp),     32'd0);
        check("rst_sel_out",   32'(sel_out),   32'd0);
        check("rst_free",      32'(free),      32'd0);
        check("rst_press_out", 32'(press_out), 32'd0);
        check("rst_err_sel",   32'(err_sel),   32'd0);
        check("rst_occupied",  32'(occupied),  32'd0);
        check("rst_occ_count", 32'(occ_count), 32'd0);
        check("rst_full",      32'(full),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            check("idle_timer", 32'(timer), 32'(timer_m()));
            check("idle_press_out", 32'(press_out), 32'd0);
        end
    endtask

    task automatic wait_until_n(input int target);
        int guard;
        guard = 0;
        while (n_edges < target && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    // One button press: raw high for 'hold' cycles, then released long enough
    // for the release to debounce. Checks strobe timing cycle by cycle.
    task automatic do_press(input logic [3:0] sel, input int hold);
        int  n0;
        bit  debounced;
        bit  acc;
        bit  valid;
        @(posedge clk);
        #1;
        selector  = sel;
        press_raw = 1'b1;
        n0        = n_edges;
        debounced = (hold >= DEBOUNCE);
        acc       = debounced && armed_m;
        valid     = (sel >= 4'd1) && (sel <= 4'd6);
        for (int k = 1; k <= hold + 10; k++) begin
            @(posedge clk);
            #1;
            if (k == hold) press_raw = 1'b0;
            if (k == A_OFS) begin
                check("pre_commit_occupied", 32'(occupied), 32'(occ_vec()));
            end
            if (k == A_OFS + 1 && acc && valid) begin
                free_m      = !occ_m[sel];
                occ_m[sel]  = !occ_m[sel];
                sel_m       = sel;
                stamp_m     = 11'(((n0 + A_OFS) / MIN_DIV) % 2048);
            end
            check("press_out", 32'(press_out), 32'(acc && valid && (k == A_OFS + 2)));
            check("err_sel",   32'(err_sel),   32'(acc && !valid && (k == A_OFS + 1)));
            check("timer",     32'(timer),     32'(timer_m()));
            if (k == A_OFS + 1 || k == A_OFS + 2) check_all("commit");
        end
        if (debounced) armed_m = 1'b1;
        check_all("after_press");
    endtask

    initial begin
        logic [3:0] rsel;
        int         rhold;

        model_reset();
        apply_reset();

        // Arming press (not accepted), then basic check-in at timer 5.
        do_press(4'd3, 4);
        do_press(4'd3, 6);
        check("checkin_stamp",    32'(stamp),     32'd5);
        check("checkin_occupied", 32'(occupied),  32'b000100);
        check("checkin_free",     32'(free),      32'd1);
        check("checkin_count",    32'(occ_count), 32'd1);

        // Check-out of the same bay at timer 9.
        do_press(4'd3, 6);
        check("checkout_stamp",    32'(stamp),    32'd9);
        check("checkout_occupied", 32'(occupied), 32'd0);
        check("checkout_free",     32'(free),     32'd0);

        // Invalid selectors.
        do_press(4'd0, 6);
        do_press(4'd7, 6);

        // Glitch shorter than DEBOUNCE.
        do_press(4'd2, 3);

        // Fill every bay.
        for (int b = 1; b <= 6; b++) do_press(4'(b), 5);
        check("fill_full",  32'(full),      32'd1);
        check("fill_count", 32'(occ_count), 32'd6);

        // Timer wrap 2047 -> 0.
        wait_until_n(MIN_DIV * 2048 - 1);
        check("wrap_top", 32'(timer), 32'd2047);
        @(posedge clk);
        #1;
        check("wrap_zero", 32'(timer), 32'd0);

        do_press(4'd6, 6);
        check("unfill_full", 32'(full), 32'd0);

        // Randomized presses, glitches and gaps.
        for (int r = 0; r < 30; r++) begin
            rsel  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 6));
            rhold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3)
                                                : $urandom_range(4, 8);
            do_press(rsel, rhold);
            idle($urandom_range(0, 5));
        end

        // Button held through reset: ignored until released and pressed again.
        press_raw = 1'b1;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check("held_press_out", 32'(press_out), 32'd0);
            check("held_err_sel",   32'(err_sel),   32'd0);
        end
        armed_m   = 1'b1;
        press_raw = 1'b0;
        idle(10);
        do_press(4'd5, 6);
        check("held_then_press_occ", 32'(occupied), 32'b010000);

        // Reset asserted in A+1 aborts the strobe.
        @(posedge clk);
        #1;
        selector  = 4'd2;
        press_raw = 1'b1;
        for (int k = 1; k <= A_OFS + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) press_raw = 1'b0;
        end
        check("abort_a1_occupied", 32'(occupied), 32'b010010);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_press_out", 32'(press_out), 32'd0);
        check("abort_occupied",  32'(occupied),  32'd0);
        check("abort_timer",     32'(timer),     32'd0);
        check("abort_err_sel",   32'(err_sel),   32'd0);
        apply_reset();
        idle(3);

        // Minute tick coinciding with the accept cycle at timer 10.
        do_press(4'd1, 6);
        wait_until_n(36);
        do_press(4'd4, 6);
        check("tick_stamp", 32'(stamp), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
